bus_glue: RTL
=============

BUS_GLUE -- requirements
Module: bus_glue

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 4: number of bus cycles with the boot ROM overlay active (1..255).
REQ-002 SHALL have parameter RESET_STRETCH, default 16: clocks that RESET/HALT stay asserted after i_HWRST releases (2..1023).
REQ-003 SHALL have parameter BERR_TIMEOUT, default 64: clocks of AS low without DTACK before bus error (4..1023).
REQ-004 SHALL have parameter NUM_IACK, default 2: number of IACK channels (1..7).
REQ-005 SHALL have parameter IACK_BASE, default 4: IPL level decoded for channel 0; channel k decodes level IACK_BASE+k, and IACK_BASE+NUM_IACK-1 SHALL NOT exceed 7.
REQ-006 SHALL have ports:
 i_CLK  in  1  system clock; all state updates on rising edge
 i_RST  in  1  synchronous active-high reset
 i_HWRST  in  1  asynchronous reset button, active-high
 i_AS_n  in  1  68k address strobe
 i_DTACK_n  in  1  data transfer acknowledge, observed only
 i_A  in  1  address bit 19
 i_A_LOW  in  3  address bits 3:1
 i_FC  in  3  function code
 o_HALT_n  out  1  0 or Z (open-drain)
 o_RESET_n  out  1  0 or Z (open-drain)
 o_RUNLED  out  1  1 in RUN state
 o_BOOT  out  1  0 = boot overlay active
 o_CPUSP_n  out  1  0 = CPU-space cycle (FC=111)
 o_IACK_n  out  NUM_IACK  per-channel interrupt acknowledge, active-low
 o_BERR_n  out  1  0 or Z (open-drain) bus error

Function
REQ-007 SHALL synchronise i_HWRST and i_AS_n through two flops each; all logic uses the synchronised copies.
REQ-008 SHALL implement states RESET, STRETCH, RUN: RESET->STRETCH when synced HWRST=0; STRETCH->RUN after exactly RESET_STRETCH clocks in STRETCH; any state->RESET when synced HWRST=1.
REQ-009 SHALL drive o_RESET_n and o_HALT_n to 0 in RESET and STRETCH, Z in RUN; o_RUNLED=1 only in RUN.
REQ-010 SHALL detect a bus-cycle end as a 0->1 transition of synced AS; transitions are counted only in RUN.
REQ-011 SHALL hold o_BOOT=0 from RUN entry until the BOOT_CYCLES-th counted cycle end, then set o_BOOT=1 on the next clock and keep it until the next RESET; the counter SHALL saturate and not wrap.
REQ-012 SHALL drive o_CPUSP_n=0 combinationally when FC=111 and state is RUN, else 1.
REQ-013 SHALL drive o_IACK_n[k]=0 combinationally when o_CPUSP_n=0, i_AS_n=0, i_A=1 and i_A_LOW=IACK_BASE+k; all other bits 1.
REQ-014 SHALL count clocks while synced AS=0 and i_DTACK_n=1 in RUN; count clears when AS=1 or DTACK=0.
REQ-015 SHALL drive o_BERR_n=0 from the clock the count reaches BERR_TIMEOUT until synced AS returns to 1, then Z; the counter SHALL saturate at BERR_TIMEOUT.
REQ-016 SHALL give DTACK priority: if DTACK=0 on the clock the count would reach BERR_TIMEOUT, o_BERR_n stays Z.
REQ-017 SHALL, on HWRST during an active bus error, release o_BERR_n to Z on the clock RESET is entered.

Reset
REQ-018 SHALL, on i_RST=1, enter RESET, clear all counters and synchronisers to idle (HWRST=0, AS=1), o_BOOT=0, o_BERR_n=Z, o_RUNLED=0, o_RESET_n=o_HALT_n=0.
REQ-019 SHALL treat synced HWRST=1 identically to i_RST except synchroniser flops.

Configuration
REQ-020 SHALL, with macro GLUE_BERR_WATCHDOG_EN defined, include the bus-error watchdog (REQ-014..017).
REQ-021 SHALL, without GLUE_BERR_WATCHDOG_EN, omit the watchdog counter and hold o_BERR_n at Z permanently.

Verification
REQ-022 SHALL cover: i_HWRST pulse 5 clocks, RESET_STRETCH=16 -> o_RESET_n=0 until 16 clocks after synced release, then Z and o_RUNLED=1.
REQ-023 SHALL cover: BOOT_CYCLES=4, 6 AS cycles in RUN -> o_BOOT=0 through 4th AS rise, 1 one clock later, stays 1.
REQ-024 SHALL cover: FC=111, A19=1, A_LOW=101, AS=0, NUM_IACK=2 -> o_IACK_n=01; A_LOW=011 -> o_IACK_n=11.
REQ-025 SHALL cover: AS held low 70 clocks, no DTACK, BERR_TIMEOUT=64 -> o_BERR_n=0 at count 64 until AS rises; DTACK at count 64 -> no BERR.
REQ-026 SHALL cover: i_HWRST asserted mid-STRETCH and after 2 boot cycles -> stretch restarts, o_BOOT=0, boot count restarts from 0.

Source files
------------

// File: rtl/bus_glue.sv
// 68k bus glue: reset sequencing, boot overlay, CPU-space/IACK decode.
// Optional bus-error watchdog enabled by macro GLUE_BERR_WATCHDOG_EN.
module bus_glue #(
    parameter int BOOT_CYCLES   = 4,
    parameter int RESET_STRETCH = 16,
    parameter int BERR_TIMEOUT  = 64,
    parameter int NUM_IACK      = 2,
    parameter int IACK_BASE     = 4
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_HWRST,
    input  logic                i_AS_n,
    input  logic                i_DTACK_n,
    input  logic                i_A,
    input  logic [2:0]          i_A_LOW,
    input  logic [2:0]          i_FC,
    output logic                o_HALT_n,
    output logic                o_RESET_n,
    output logic                o_RUNLED,
    output logic                o_BOOT,
    output logic                o_CPUSP_n,
    output logic [NUM_IACK-1:0] o_IACK_n,
    output logic                o_BERR_n
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_STRETCH,
        ST_RUN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       hw_s1;
    logic       hw_s2;
    logic       as_s1;
    logic       as_s2;
    logic       as_d;
    logic [9:0] str_cnt;
    logic [9:0] str_cnt_nxt;
    logic [7:0] boot_cnt;
    logic       clr;
    logic       run;
    logic       as_rise;
    logic       cpu_space;

    // two-flop synchronisers; as_d is the delayed copy for edge detect
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            hw_s1 <= 1'b0;
            hw_s2 <= 1'b0;
            as_s1 <= 1'b1;
            as_s2 <= 1'b1;
            as_d  <= 1'b1;
        end else begin
            hw_s1 <= i_HWRST;
            hw_s2 <= hw_s1;
            as_s1 <= i_AS_n;
            as_s2 <= as_s1;
            as_d  <= as_s2;
        end
    end

    assign clr     = i_RST | hw_s2;
    assign run     = (state == ST_RUN);
    assign as_rise = as_s2 & ~as_d;

    // state register and stretch counter
    always_ff @(posedge i_CLK) begin
        if (clr) begin
            state   <= ST_RESET;
            str_cnt <= '0;
        end else begin
            state   <= state_nxt;
            str_cnt <= str_cnt_nxt;
        end
    end

    // next state: stay in STRETCH exactly RESET_STRETCH clocks
    always_comb begin
        state_nxt   = state;
        str_cnt_nxt = '0;
        case (state)
            ST_RESET: state_nxt = ST_STRETCH;
            ST_STRETCH: begin
                if (str_cnt == 10'(RESET_STRETCH - 1))
                    state_nxt = ST_RUN;
                else
                    str_cnt_nxt = str_cnt + 10'd1;
            end
            ST_RUN: state_nxt = ST_RUN;
            default: state_nxt = ST_RESET;
        endcase
    end

    // boot overlay: count bus-cycle ends in RUN, saturating
    always_ff @(posedge i_CLK) begin
        if (clr)
            boot_cnt <= '0;
        else if (run && as_rise && boot_cnt != 8'(BOOT_CYCLES))
            boot_cnt <= boot_cnt + 8'd1;
    end

    assign o_BOOT    = (boot_cnt == 8'(BOOT_CYCLES));
    assign o_RUNLED  = run;
    assign o_RESET_n = run ? 1'bz : 1'b0;
    assign o_HALT_n  = run ? 1'bz : 1'b0;
    assign cpu_space = run && (i_FC == 3'b111);
    assign o_CPUSP_n = ~cpu_space;

    // interrupt acknowledge decode, one channel per IPL level
    always_comb begin
        o_IACK_n = '1;
        for (int k = 0; k < NUM_IACK; k++) begin
            if (cpu_space && !i_AS_n && i_A
                && i_A_LOW == 3'(IACK_BASE + k))
                o_IACK_n[k] = 1'b0;
        end
    end

`ifdef GLUE_BERR_WATCHDOG_EN
    logic [9:0] berr_cnt;
    logic [9:0] berr_cnt_nxt;
    logic       berr;

    // count unacknowledged strobe clocks; DTACK clears the count
    always_comb begin
        berr_cnt_nxt = '0;
        if (run && !as_s2 && i_DTACK_n) begin
            if (berr_cnt == 10'(BERR_TIMEOUT))
                berr_cnt_nxt = berr_cnt;
            else
                berr_cnt_nxt = berr_cnt + 10'd1;
        end
    end

    // bus error held until the strobe is released
    always_ff @(posedge i_CLK) begin
        if (clr) begin
            berr_cnt <= '0;
            berr     <= 1'b0;
        end else begin
            berr_cnt <= berr_cnt_nxt;
            if (!run || as_s2)
                berr <= 1'b0;
            else if (berr_cnt_nxt == 10'(BERR_TIMEOUT))
                berr <= 1'b1;
        end
    end

    assign o_BERR_n = berr ? 1'b0 : 1'bz;
`else
    logic unused_dtack;
    assign unused_dtack = i_DTACK_n;
    assign o_BERR_n     = 1'bz;
`endif

endmodule
